// File: rtl/csr_file.sv
// M-mode CSR file: combinational read at csr_addr_i, writes commit on the next clk_i edge.
// Optional 64-bit mcycle/cycle counter built only when CSR_COUNTERS_EN is defined; no backpressure.
module csr_file (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [11:0] csr_addr_i,
    input  logic        csr_wr_en_i,
    input  logic [31:0] csr_data_i,
    output logic [31:0] csr_data_o
);

    localparam logic [31:0] MISA_VAL = 32'h4000_1105;

    logic        mstatus_mie_q,  mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic [31:0] mie_q,      mie_d;
    logic [29:0] mtvec_q,    mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [30:0] mepc_q,     mepc_d;
    logic [31:0] mcause_q,   mcause_d;
    logic [31:0] mtval_q,    mtval_d;

    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
        if (csr_wr_en_i) begin
            case (csr_addr_i)
                12'h300: begin
                    mstatus_mie_d  = csr_data_i[3];
                    mstatus_mpie_d = csr_data_i[7];
                end
                12'h304: mie_d      = csr_data_i & 32'h0000_0888;
                12'h305: mtvec_d    = csr_data_i[31:2];
                12'h340: mscratch_d = csr_data_i;
                12'h341: mepc_d     = csr_data_i[31:1];
                12'h342: mcause_d   = csr_data_i;
                12'h343: mtval_d    = csr_data_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mtvec_q        <= '0;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
        end
    end

`ifdef CSR_COUNTERS_EN
    logic [31:0] mcycle_lo_q, mcycle_lo_d;
    logic [31:0] mcycle_hi_q, mcycle_hi_d;
    logic [32:0] lo_inc;
    logic        wr_lo, wr_hi;

    assign wr_lo  = csr_wr_en_i && (csr_addr_i == 12'hB00);
    assign wr_hi  = csr_wr_en_i && (csr_addr_i == 12'hB80);
    assign lo_inc = {1'b0, mcycle_lo_q} + 33'd1;

    // A high-word write wins over the carry; a low-word write freezes the high word.
    always_comb begin
        mcycle_lo_d = wr_lo ? csr_data_i : lo_inc[31:0];
        if (wr_hi)
            mcycle_hi_d = csr_data_i;
        else if (wr_lo)
            mcycle_hi_d = mcycle_hi_q;
        else
            mcycle_hi_d = mcycle_hi_q + {31'd0, lo_inc[32]};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mcycle_lo_q <= '0;
            mcycle_hi_q <= '0;
        end else begin
            mcycle_lo_q <= mcycle_lo_d;
            mcycle_hi_q <= mcycle_hi_d;
        end
    end
`endif

    always_comb begin
        csr_data_o = '0;
        case (csr_addr_i)
            12'h300: csr_data_o = {19'd0, 2'b11, 3'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
            12'h301: csr_data_o = MISA_VAL;
            12'h304: csr_data_o = mie_q;
            12'h305: csr_data_o = {mtvec_q, 2'b00};
            12'h340: csr_data_o = mscratch_q;
            12'h341: csr_data_o = {mepc_q, 1'b0};
            12'h342: csr_data_o = mcause_q;
            12'h343: csr_data_o = mtval_q;
`ifdef CSR_COUNTERS_EN
            12'hB00, 12'hC00: csr_data_o = mcycle_lo_q;
            12'hB80, 12'hC80: csr_data_o = mcycle_hi_q;
`endif
            default: csr_data_o = '0;
        endcase
    end

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file; counter expectations follow CSR_COUNTERS_EN.
module tb_csr_file;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [11:0] csr_addr_i;
    logic        csr_wr_en_i;
    logic [31:0] csr_data_i;
    logic [31:0] csr_data_o;

    int checks = 0;
    int fails  = 0;

    csr_file dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .csr_addr_i  (csr_addr_i),
        .csr_wr_en_i (csr_wr_en_i),
        .csr_data_i  (csr_data_i),
        .csr_data_o  (csr_data_o)
    );

    always #10 clk_i = ~clk_i;

    // Present an address with no write strobe and compare read data 1 ns later.
    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_addr_i  = a;
        csr_wr_en_i = 1'b0;
        #1;
        checks++;
        assert (csr_data_o === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, csr_data_o, exp);
        end
    endtask

    // Hold a write strobe across exactly one rising edge.
    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_addr_i  = a;
        csr_data_i  = d;
        csr_wr_en_i = 1'b1;
        @(posedge clk_i);
        #1;
        csr_wr_en_i = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i       = 1'b1;
        csr_addr_i  = '0;
        csr_wr_en_i = 1'b0;
        csr_data_i  = '0;
        repeat (3) @(posedge clk_i);
        #1;

        rd("rst_mstatus", 12'h300, 32'h0000_1800);
        rd("rst_misa",    12'h301, 32'h4000_1105);
        rd("rst_mhartid", 12'hF14, 32'h0000_0000);
        rd("rst_mcause",  12'h342, 32'h0000_0000);
        rst_i = 1'b0;

`ifdef CSR_COUNTERS_EN
        repeat (10) tick();
        rd("cyc_lo_10",   12'hC00, 32'd10);
        rd("cyc_hi_0",    12'hC80, 32'd0);
        wr(12'hB00, 32'hFFFF_FFFF);
        rd("mcyc_lo_set", 12'hB00, 32'hFFFF_FFFF);
        tick();
        rd("mcyc_lo_wrap", 12'hB00, 32'h0);
        rd("mcyc_hi_carry", 12'hB80, 32'h1);
        rd("cyc_hi_alias", 12'hC80, 32'h1);
        wr(12'hC00, 32'h0000_0055);
        rd("cyc_ro_alias", 12'hC00, 32'h1);
        wr(12'hB80, 32'h0000_0007);
        rd("mcyc_hi_wr",  12'hB80, 32'h7);
        rd("mcyc_lo_inc", 12'hB00, 32'h2);
        wr(12'hB00, 32'hFFFF_FFFF);
        wr(12'hB80, 32'h0000_0009);
        rd("carry_drop_hi", 12'hB80, 32'h9);
        rd("carry_drop_lo", 12'hB00, 32'h0);
        wr(12'hB80, 32'hFFFF_FFFF);
        wr(12'hB00, 32'hFFFF_FFFF);
        rd("pre_wrap_hi", 12'hB80, 32'hFFFF_FFFF);
        tick();
        rd("wrap64_lo",   12'hB00, 32'h0);
        rd("wrap64_hi",   12'hB80, 32'h0);
`else
        repeat (100) tick();
        rd("nocnt_b00",   12'hB00, 32'h0);
        wr(12'hB00, 32'h0000_0005);
        rd("nocnt_b00_wr", 12'hB00, 32'h0);
        rd("nocnt_c00",   12'hC00, 32'h0);
        rd("nocnt_b80",   12'hB80, 32'h0);
`endif

        wr(12'h300, 32'hFFFF_FFFF);
        rd("mstatus_mask", 12'h300, 32'h0000_1888);
        wr(12'h304, 32'hFFFF_FFFF);
        rd("mie_mask",     12'h304, 32'h0000_0888);
        wr(12'h305, 32'hFFFF_FFFF);
        rd("mtvec_mask",   12'h305, 32'hFFFF_FFFC);
        wr(12'h341, 32'hFFFF_FFFF);
        rd("mepc_mask",    12'h341, 32'hFFFF_FFFE);
        wr(12'h343, 32'hA5A5_5A5A);
        rd("mtval_full",   12'h343, 32'hA5A5_5A5A);
        wr(12'h300, 32'h0000_0008);
        rd("mstatus_mie_only", 12'h300, 32'h0000_1808);

        // Same-cycle read must still show the old value: no bypass.
        csr_addr_i  = 12'h340;
        csr_data_i  = 32'hDEAD_BEEF;
        csr_wr_en_i = 1'b1;
        #1;
        checks++;
        assert (csr_data_o === 32'h0)
        else begin
            fails++;
            $error("FAIL mscratch_no_bypass: observed %h expected %h", csr_data_o, 32'h0);
        end
        @(posedge clk_i);
        #1;
        rd("mscratch_next", 12'h340, 32'hDEAD_BEEF);

        wr(12'h301, 32'h0000_0000);
        rd("misa_ro",      12'h301, 32'h4000_1105);
        wr(12'h344, 32'hFFFF_FFFF);
        rd("mip_ro",       12'h344, 32'h0);
        wr(12'h7C0, 32'h1234_5678);
        rd("unimpl_zero",  12'h7C0, 32'h0);

        wr(12'h342, 32'h0000_00AA);
        rd("mcause_wr",    12'h342, 32'h0000_00AA);
        rst_i = 1'b1;
        wr(12'h342, 32'h0000_1234);
        rd("rst_over_wr",  12'h342, 32'h0);
        rd("rst2_mstatus", 12'h300, 32'h0000_1800);
        rd("rst2_mscratch", 12'h340, 32'h0);
`ifdef CSR_COUNTERS_EN
        rd("rst2_cycle",   12'hC00, 32'h0);
`endif
        rst_i = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
